duck_round_ctrl: RTL
====================

Name: duck_round_ctrl

Overview:
Round sequencer for the duck-hunt gameplay layer. Runs one duck at a time through spawn, flight, hit/escape and score bookkeeping. Requests a fresh random position from the position generator on every spawn and latches it as the current duck position for the drawing pipeline. Sits between the top-level game state machine and the duck/score rendering blocks.

Parameters:
TICK_DIV, 65_000_000, clk cycles per game-time tick (1 s at 65 MHz); benches use small values
DUCK_TICKS, 6, ticks a duck stays on screen before escaping
HIT_TICKS, 1, ticks the shot-duck sprite is held before the next spawn
DUCKS_PER_ROUND, 10, ducks per round
X_MAX, 960, largest legal duck x; larger random values are replaced by X_DEFAULT
X_DEFAULT, 450, fallback x
Y_MIN, 96, smallest legal duck y
Y_MAX, 607, largest legal duck y; out-of-range values are replaced by Y_DEFAULT
Y_DEFAULT, 352, fallback y

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
state  in  2  game state from top FSM; 2'b01 = PLAY, any other value = not playing
clicked_duck  in  1  one-cycle pulse: mouse click landed on the duck
rnd_hor  in  10  random x from the position generator
rnd_ver  in  10  random y from the position generator
pos_req  out  1  one-cycle pulse: advance the position generator
duck_x  out  10  latched duck x
duck_y  out  10  latched duck y
duck_visible  out  1  duck is on screen (ACTIVE or HIT)
duck_shot  out  1  high during HIT (renderer draws falling sprite)
escaped  out  1  one-cycle pulse when a duck times out
score  out  8  ducks hit this round
misses  out  8  ducks escaped this round
round_done  out  1  high in DONE until state leaves PLAY

Behaviour:
- Reset (async, rst=1): FSM=IDLE, all outputs 0, duck_x=X_DEFAULT, duck_y=Y_DEFAULT, tick prescaler and counters 0.
- Tick prescaler: counts 0..TICK_DIV-1 only while FSM in ACTIVE or HIT; tick pulse at TICK_DIV-1; cleared on every FSM state change.
- States: IDLE, SPAWN_REQ, SPAWN_WAIT, ACTIVE, HIT, DONE.
- IDLE: waits for state==PLAY; on entry to PLAY clears score, misses, duck counter; next cycle SPAWN_REQ.
- SPAWN_REQ: pos_req=1 for exactly this cycle; -> SPAWN_WAIT.
- SPAWN_WAIT: one cycle for generator register update; at the end latches position: duck_x = rnd_hor if rnd_hor<=X_MAX else X_DEFAULT; duck_y = rnd_ver if Y_MIN<=rnd_ver<=Y_MAX else Y_DEFAULT; -> ACTIVE. duck_visible rises 2 cycles after SPAWN_REQ entry.
- ACTIVE: tick counter counts DUCK_TICKS; clicked_duck -> HIT, score+1; timeout -> escaped pulse, misses+1, duck counter+1, then SPAWN_REQ or DONE.
- Click and timeout in same cycle: hit wins, no escaped pulse.
- HIT: duck_shot=1, clicks ignored; after HIT_TICKS ticks duck counter+1 -> SPAWN_REQ, or DONE if counter reaches DUCKS_PER_ROUND.
- DONE: round_done=1, duck_visible=0; score/misses held; leaves to IDLE when state!=PLAY.
- clicked_duck outside ACTIVE: ignored.
- state leaves PLAY in any state: next cycle IDLE, duck_visible/duck_shot/pos_req 0; score/misses held for display until next PLAY entry.
- score/misses saturate at 255 (unreachable with defaults, still required).
- Counter widths: tick counter ceil(log2(TICK_DIV)); duck/tick counters 8 bit.

Decomposition:
- Shared game package: game-state encodings (PLAY=2'b01 etc.), screen limits X_MAX/Y_MIN/Y_MAX, default duck position; same constants used by the position generator and renderer.
- One sub-module: tick_prescaler (count, clear, enable, tick pulse), reusable by the game timer.

Test Plan:
- rst mid-ACTIVE -> same-cycle outputs 0, duck_x=450, duck_y=352, FSM IDLE.
- state=01 with rnd_hor=300, rnd_ver=200 -> pos_req pulse 1 cycle, duck_visible 2 cycles later, duck_x=300, duck_y=200.
- rnd_hor=1000, rnd_ver=50 -> duck_x=450, duck_y=352.
- TICK_DIV=4, DUCK_TICKS=6, no click -> escaped at 24 cycles after ACTIVE entry, misses=1, new pos_req next cycle.
- Click and timeout same cycle -> score=1, misses=0, no escaped, duck_shot for HIT_TICKS*TICK_DIV cycles.
- 10 ducks (7 hit, 3 escaped) -> round_done=1, score=7, misses=3; state=00 -> IDLE, values held; state=01 again -> counters cleared.

Source files
------------

// File: rtl/duck_round_ctrl_pkg.sv
// Shared game constants: top-FSM state codes, screen limits, default duck spot.
// Also used by the position generator and the renderers.
package duck_round_ctrl_pkg;

    typedef logic [9:0] coord_t;

    localparam logic [1:0] GS_MENU = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_OVER = 2'b10;

    localparam int SCR_X_MAX = 960;
    localparam int SCR_Y_MIN = 96;
    localparam int SCR_Y_MAX = 607;
    localparam int DEF_X     = 450;
    localparam int DEF_Y     = 352;

    // Keep v if it lies in [lo, hi], otherwise fall back to dflt.
    function automatic coord_t fit(
        input coord_t v,
        input coord_t lo,
        input coord_t hi,
        input coord_t dflt
    );
        return (v < lo || v > hi) ? dflt : v;
    endfunction

endpackage

// File: rtl/duck_round_ctrl_if.sv
// Bundle between the game top FSM / position generator and the round sequencer.
// master = environment side, slave = sequencer side.
interface duck_round_ctrl_if;

    logic [1:0] state;
    logic       clicked_duck;
    logic [9:0] rnd_hor;
    logic [9:0] rnd_ver;
    logic       pos_req;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic       duck_visible;
    logic       duck_shot;
    logic       escaped;
    logic [7:0] score;
    logic [7:0] misses;
    logic       round_done;

    modport master (
        output state, clicked_duck, rnd_hor, rnd_ver,
        input  pos_req, duck_x, duck_y, duck_visible, duck_shot,
        input  escaped, score, misses, round_done
    );

    modport slave (
        input  state, clicked_duck, rnd_hor, rnd_ver,
        output pos_req, duck_x, duck_y, duck_visible, duck_shot,
        output escaped, score, misses, round_done
    );

endinterface

// File: rtl/duck_round_ctrl_tick_prescaler.sv
// Game-time prescaler: counts 0..DIV-1 while enabled, pulses tick on DIV-1.
// A synchronous clear restarts the count (used on every owner state change).
module duck_round_ctrl_tick_prescaler #(
    parameter int DIV = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Free-run while enabled, wrap on tick, restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/duck_round_ctrl.sv
// Round sequencer: spawn, flight, hit/escape and score bookkeeping,
// one duck at a time, for the duck-hunt gameplay layer.
module duck_round_ctrl
    import duck_round_ctrl_pkg::*;
#(
    parameter int TICK_DIV        = 65_000_000,
    parameter int DUCK_TICKS      = 6,
    parameter int HIT_TICKS       = 1,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int X_MAX           = SCR_X_MAX,
    parameter int X_DEFAULT       = DEF_X,
    parameter int Y_MIN           = SCR_Y_MIN,
    parameter int Y_MAX           = SCR_Y_MAX,
    parameter int Y_DEFAULT       = DEF_Y
) (
    input logic         clk,
    input logic         rst,
    duck_round_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_HIT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam coord_t X_HI  = 10'(X_MAX);
    localparam coord_t X_DEF = 10'(X_DEFAULT);
    localparam coord_t Y_LO  = 10'(Y_MIN);
    localparam coord_t Y_HI  = 10'(Y_MAX);
    localparam coord_t Y_DEF = 10'(Y_DEFAULT);

    localparam logic [7:0] DUCK_LAST = 8'(DUCK_TICKS - 1);
    localparam logic [7:0] HIT_LAST  = 8'(HIT_TICKS - 1);
    localparam logic [7:0] ROUND_LAST = 8'(DUCKS_PER_ROUND - 1);

    logic [2:0] fsm;
    logic [2:0] nxt;
    logic       play;
    logic       tick;
    logic       moving;
    logic       timeout;
    logic       hit_end;
    logic       last;
    logic       click;
    logic       esc;
    logic [7:0] tick_cnt;
    logic [7:0] duck_cnt;
    logic [7:0] score;
    logic [7:0] misses;
    coord_t     x_q;
    coord_t     y_q;

    assign play    = (bus.state == GS_PLAY);
    assign moving  = (fsm == S_ACT) || (fsm == S_HIT);
    assign timeout = tick && (tick_cnt == DUCK_LAST);
    assign hit_end = tick && (tick_cnt == HIT_LAST);
    assign last    = (duck_cnt >= ROUND_LAST);
    // A click on the timeout cycle still counts as a hit.
    assign click   = play && (fsm == S_ACT) && bus.clicked_duck;
    assign esc     = play && (fsm == S_ACT) && !bus.clicked_duck && timeout;

    duck_round_ctrl_tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (nxt != fsm),
        .en   (moving),
        .tick (tick)
    );

    // Next-state decode; leaving PLAY aborts to IDLE from anywhere.
    always_comb begin
        nxt = fsm;
        if (!play) begin
            nxt = S_IDLE;
        end else begin
            unique case (fsm)
                S_IDLE: nxt = S_REQ;
                S_REQ:  nxt = S_WAIT;
                S_WAIT: nxt = S_ACT;
                S_ACT: begin
                    if (click)
                        nxt = S_HIT;
                    else if (timeout)
                        nxt = last ? S_DONE : S_REQ;
                end
                S_HIT: begin
                    if (hit_end)
                        nxt = last ? S_DONE : S_REQ;
                end
                S_DONE: nxt = S_DONE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fsm <= S_IDLE;
        else
            fsm <= nxt;
    end

    // Ticks spent in the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (nxt != fsm)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= tick_cnt + 8'd1;
    end

    // Score, misses and ducks-flown bookkeeping; cleared on PLAY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score    <= '0;
            misses   <= '0;
            duck_cnt <= '0;
        end else if (play) begin
            if (fsm == S_IDLE) begin
                score    <= '0;
                misses   <= '0;
                duck_cnt <= '0;
            end else if (click) begin
                if (score != 8'hFF)
                    score <= score + 8'd1;
            end else if (esc) begin
                if (misses != 8'hFF)
                    misses <= misses + 8'd1;
                duck_cnt <= duck_cnt + 8'd1;
            end else if (fsm == S_HIT && hit_end) begin
                duck_cnt <= duck_cnt + 8'd1;
            end
        end
    end

    // Capture the generator output once it has settled after pos_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= X_DEF;
            y_q <= Y_DEF;
        end else if (play && fsm == S_WAIT) begin
            x_q <= fit(bus.rnd_hor, 10'd0, X_HI, X_DEF);
            y_q <= fit(bus.rnd_ver, Y_LO, Y_HI, Y_DEF);
        end
    end

    assign bus.pos_req      = (fsm == S_REQ);
    assign bus.duck_x       = x_q;
    assign bus.duck_y       = y_q;
    assign bus.duck_visible = moving;
    assign bus.duck_shot    = (fsm == S_HIT);
    assign bus.escaped      = esc;
    assign bus.score        = score;
    assign bus.misses       = misses;
    assign bus.round_done   = (fsm == S_DONE);

endmodule
